// File: rtl/i2c_decode_filt_if.sv
// Bundle of the raw I2C lines and the decoded bus events of the slave front-end.
// The master side drives the lines; the slave side is the decoder.
`timescale 1ns/1ps
interface i2c_decode_filt_if;
    logic       scl;
    logic       sda_in;
    logic       start_found;
    logic       stop_found;
    logic       rep_start;
    logic       bus_busy;
    logic [7:0] starting_byte;
    logic       byte_valid;
    logic       address_match;
    logic       gen_call;
    logic       rw_mode;

    modport master (
        output scl, sda_in,
        input  start_found, stop_found, rep_start, bus_busy, starting_byte,
               byte_valid, address_match, gen_call, rw_mode
    );

    modport slave (
        input  scl, sda_in,
        output start_found, stop_found, rep_start, bus_busy, starting_byte,
               byte_valid, address_match, gen_call, rw_mode
    );
endinterface

// File: rtl/i2c_decode_filt.sv
// I2C slave front-end: synchronises and glitch-filters SCL/SDA, detects START/STOP/
// repeated START and decodes the first byte after each START against the slave address.
`timescale 1ns/1ps
module i2c_decode_filt #(
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 3,
    parameter logic [6:0] SLAVE_ADDR  = 7'h78,
    parameter logic [6:0] ADDR_MASK   = 7'h7F,
    parameter logic       GEN_CALL_EN = 1'b1
) (
    input logic              clk,
    input logic              rst,
    i2c_decode_filt_if.slave bus
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic [CW-1:0]          scl_cnt_q, sda_cnt_q;
    logic                   scl_filt_q, sda_filt_q, scl_prev_q, sda_prev_q;
    logic                   scl_sync_s, sda_sync_s;

    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] byte_q;
    logic       start_found_q, stop_found_q, rep_start_q, bus_busy_q;
    logic       byte_valid_q, address_match_q, gen_call_q, rw_mode_q;

    logic       start_s, stop_s, scl_rise_s;
    logic [7:0] byte_next_s;
    logic       addr_hit_s, gen_call_s;

    assign scl_sync_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_sync_s = sda_sync_q[SYNC_STAGES-1];

    // Synchronise both lines, then let the filtered copy follow only after FILTER_LEN stable clocks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
            scl_prev_q <= scl_filt_q;
            sda_prev_q <= sda_filt_q;
            if (scl_sync_s == scl_filt_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == CW'(FILTER_LEN - 1)) begin
                scl_filt_q <= scl_sync_s;
                scl_cnt_q  <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + CW'(1);
            end
            if (sda_sync_s == sda_filt_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == CW'(FILTER_LEN - 1)) begin
                sda_filt_q <= sda_sync_s;
                sda_cnt_q  <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + CW'(1);
            end
        end
    end

    // START and STOP need SCL high on both cycles, so neither can coincide with an SCL rise
    assign start_s     = scl_filt_q & scl_prev_q & sda_prev_q & ~sda_filt_q;
    assign stop_s      = scl_filt_q & scl_prev_q & ~sda_prev_q & sda_filt_q;
    assign scl_rise_s  = scl_filt_q & ~scl_prev_q;
    assign byte_next_s = {byte_q[6:0], sda_filt_q};
    assign addr_hit_s  = (((byte_next_s[7:1] ^ SLAVE_ADDR) & ADDR_MASK) == 7'h00);
    assign gen_call_s  = GEN_CALL_EN & (byte_next_s == 8'h00);

    // Bus-state FSM with first-byte capture and registered decode outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            bit_cnt_q       <= 3'd0;
            byte_q          <= 8'h00;
            start_found_q   <= 1'b0;
            stop_found_q    <= 1'b0;
            rep_start_q     <= 1'b0;
            bus_busy_q      <= 1'b0;
            byte_valid_q    <= 1'b0;
            address_match_q <= 1'b0;
            gen_call_q      <= 1'b0;
            rw_mode_q       <= 1'b0;
        end else begin
            start_found_q <= start_s;
            stop_found_q  <= stop_s;
            rep_start_q   <= 1'b0;
            byte_valid_q  <= 1'b0;
            if (start_s || stop_s) begin
                address_match_q <= 1'b0;
                gen_call_q      <= 1'b0;
                rw_mode_q       <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start_s) begin
                        state_q    <= ADDR;
                        bit_cnt_q  <= 3'd0;
                        bus_busy_q <= 1'b1;
                    end
                end
                ADDR: begin
                    if (stop_s) begin
                        state_q    <= IDLE;
                        bus_busy_q <= 1'b0;
                    end else if (start_s) begin
                        bit_cnt_q   <= 3'd0;
                        rep_start_q <= 1'b1;
                    end else if (scl_rise_s) begin
                        byte_q <= byte_next_s;
                        if (bit_cnt_q == 3'd7) begin
                            state_q         <= DATA;
                            bit_cnt_q       <= 3'd0;
                            byte_valid_q    <= 1'b1;
                            address_match_q <= addr_hit_s | gen_call_s;
                            gen_call_q      <= gen_call_s;
                            rw_mode_q       <= byte_next_s[0];
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                end
                DATA: begin
                    if (stop_s) begin
                        state_q    <= IDLE;
                        bus_busy_q <= 1'b0;
                    end else if (start_s) begin
                        state_q     <= ADDR;
                        bit_cnt_q   <= 3'd0;
                        rep_start_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    bus_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start_found   = start_found_q;
    assign bus.stop_found    = stop_found_q;
    assign bus.rep_start     = rep_start_q;
    assign bus.bus_busy      = bus_busy_q;
    assign bus.starting_byte = byte_q;
    assign bus.byte_valid    = byte_valid_q;
    assign bus.address_match = address_match_q;
    assign bus.gen_call      = gen_call_q;
    assign bus.rw_mode       = rw_mode_q;
endmodule

// File: tb/tb_i2c_decode_filt.sv
// Directed bench for i2c_decode_filt: default instance plus one with a narrowed
// address mask and general call disabled, both fed from the same I2C lines.
`timescale 1ns/1ps
module tb_i2c_decode_filt;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   bv_count = 0;
    int   start_count = 0;

    typedef struct packed {
        logic [7:0] b;
        logic       m;
        logic       g;
        logic       rw;
    } exp_t;
    exp_t exp_q[$];

    i2c_decode_filt_if bus0 ();
    i2c_decode_filt_if bus1 ();
    assign bus1.scl    = bus0.scl;
    assign bus1.sda_in = bus0.sda_in;

    i2c_decode_filt dut0 (.clk(clk), .rst(rst), .bus(bus0));
    i2c_decode_filt #(.ADDR_MASK(7'h70), .GEN_CALL_EN(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: each completed byte is compared with the oldest queued expectation
    always @(negedge clk) begin
        if (bus0.start_found) start_count++;
        if (bus0.byte_valid) begin
            exp_t e;
            bv_count++;
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL sb_unexpected: observed byte %0h expected none", bus0.starting_byte);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_byte",  {24'h0, bus0.starting_byte}, {24'h0, e.b});
                check("sb_match", {31'h0, bus0.address_match}, {31'h0, e.m});
                check("sb_gen",   {31'h0, bus0.gen_call},      {31'h0, e.g});
                check("sb_rw",    {31'h0, bus0.rw_mode},       {31'h0, e.rw});
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus0.sda_in = b;
        wait_clks(4);
        bus0.scl = 1'b1;
        wait_clks(8);
        bus0.scl = 1'b0;
        wait_clks(4);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic m, input logic g, input logic rw);
        exp_q.push_back('{b: b, m: m, g: g, rw: rw});
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    // START from idle or repeated START; checks the 6-clock latency and the same-cycle outputs
    task automatic do_start(input string tag, input logic exp_rep);
        int lat;
        bus0.sda_in = 1'b1;
        wait_clks(4);
        bus0.scl = 1'b1;
        wait_clks(8);
        bus0.sda_in = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus0.start_found) begin
                lat = k;
                break;
            end
        end
        check({tag, "_start_lat"}, lat, 32'd6);
        check({tag, "_rep"},       {31'h0, bus0.rep_start},     {31'h0, exp_rep});
        check({tag, "_busy"},      {31'h0, bus0.bus_busy},      32'd1);
        check({tag, "_match_clr"}, {31'h0, bus0.address_match}, 32'd0);
        wait_clks(8);
        bus0.scl = 1'b0;
        wait_clks(4);
    endtask

    task automatic do_stop(input string tag);
        int lat;
        bus0.sda_in = 1'b0;
        wait_clks(4);
        bus0.scl = 1'b1;
        wait_clks(8);
        bus0.sda_in = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (bus0.stop_found) begin
                lat = k;
                break;
            end
        end
        check({tag, "_stop_lat"},  lat, 32'd6);
        check({tag, "_busy_clr"},  {31'h0, bus0.bus_busy},      32'd0);
        check({tag, "_match_clr"}, {31'h0, bus0.address_match}, 32'd0);
        wait_clks(8);
    endtask

    initial begin
        int starts_before;
        bus0.scl    = 1'b1;
        bus0.sda_in = 1'b1;
        wait_clks(3);
        check("rst_busy",  {31'h0, bus0.bus_busy},      32'd0);
        check("rst_byte",  {24'h0, bus0.starting_byte}, 32'd0);
        check("rst_match", {31'h0, bus0.address_match}, 32'd0);
        check("rst_start", {31'h0, bus0.start_found},   32'd0);
        rst = 1'b0;
        wait_clks(10);

        do_start("t1", 1'b0);
        send_byte(8'hF0, 1'b1, 1'b0, 1'b0);
        do_stop("t1");

        do_start("t2a", 1'b0);
        send_byte(8'hF1, 1'b1, 1'b0, 1'b1);
        do_stop("t2a");
        do_start("t2b", 1'b0);
        send_byte(8'hD1, 1'b0, 1'b0, 1'b1);
        do_stop("t2b");
        do_start("t2c", 1'b0);
        send_byte(8'hD0, 1'b0, 1'b0, 1'b0);
        do_stop("t2c");

        starts_before = start_count;
        bus0.sda_in = 1'b0;
        wait_clks(2);
        bus0.sda_in = 1'b1;
        wait_clks(20);
        check("t3_no_start", start_count, starts_before);
        check("t3_busy",     {31'h0, bus0.bus_busy}, 32'd0);

        do_start("t4", 1'b0);
        send_byte(8'hF0, 1'b1, 1'b0, 1'b0);
        check("t4_match_held", {31'h0, bus0.address_match}, 32'd1);
        do_start("t4r", 1'b1);
        send_byte(8'hF1, 1'b1, 1'b0, 1'b1);
        do_stop("t4");

        do_start("t5a", 1'b0);
        send_byte(8'h00, 1'b1, 1'b1, 1'b0);
        check("t5_nogc_gen",   {31'h0, bus1.gen_call},      32'd0);
        check("t5_nogc_match", {31'h0, bus1.address_match}, 32'd0);
        do_stop("t5a");
        do_start("t5b", 1'b0);
        send_byte(8'hF3, 1'b0, 1'b0, 1'b1);
        check("t5_mask_match", {31'h0, bus1.address_match}, 32'd1);
        check("t5_mask_rw",    {31'h0, bus1.rw_mode},       32'd1);
        do_stop("t5b");

        do_start("t6", 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        #2 rst = 1'b1;
        #1;
        check("t6_busy",  {31'h0, bus0.bus_busy},      32'd0);
        check("t6_byte",  {24'h0, bus0.starting_byte}, 32'd0);
        check("t6_match", {31'h0, bus0.address_match}, 32'd0);
        bus0.scl    = 1'b1;
        bus0.sda_in = 1'b1;
        wait_clks(4);
        rst = 1'b0;
        wait_clks(10);
        do_start("t6b", 1'b0);
        send_byte(8'hF0, 1'b1, 1'b0, 1'b0);
        do_stop("t6b");

        check("end_bytes", bv_count, 32'd9);
        check("end_queue", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
